// File: rtl/config_loader_if.sv
// config_loader_if: configuration word stream handshake.
// The source drives valid/data and the loader answers with ready.
interface config_loader_if #(
    parameter int WORD_W = 32
);
    logic              io_cfg_valid;
    logic [WORD_W-1:0] io_cfg_data;
    logic              io_cfg_ready;

    modport master (
        output io_cfg_valid,
        output io_cfg_data,
        input  io_cfg_ready
    );

    modport slave (
        input  io_cfg_valid,
        input  io_cfg_data,
        output io_cfg_ready
    );
endinterface

// File: rtl/config_loader.sv
// config_loader: sequences a framed word stream into the latch bank.
// One-hot enables pulse one cycle with the data bus held around them.
module config_loader #(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 39,
    parameter int IDX_W     = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 io_start,
    config_loader_if.slave       cfg,
    output logic [WORD_W-1:0]    io_d_in,
    output logic [NUM_WORDS-1:0] io_configs_en,
    output logic                 io_busy,
    output logic                 io_done,
    output logic                 io_error
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETUP,
        STROBE,
        HOLD,
        CHECK
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [NUM_WORDS-1:0] EN_ONE = NUM_WORDS'(1);

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [WORD_W-1:0]      xor_q, xor_d;
    logic [WORD_W-1:0]      data_q, data_d;
    logic [NUM_WORDS-1:0]   en_q, en_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   ready;
    logic                   accept;

    // Ready depends only on state so the source never sees a comb loop.
    always_comb begin
        ready  = (state_q == LOAD) || (state_q == CHECK);
        accept = ready && cfg.io_cfg_valid;
    end

    assign cfg.io_cfg_ready = ready;
    assign io_d_in          = data_q;
    assign io_configs_en    = en_q;
    assign io_busy          = busy_q;
    assign io_done          = done_q;
    assign io_error         = err_q;

    // Next-state and next-value logic for the frame sequencer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        xor_d   = xor_q;
        data_d  = data_q;
        en_d    = en_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (io_start) begin
                    state_d = LOAD;
                    idx_d   = '0;
                    xor_d   = '0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            LOAD: begin
                if (accept) begin
                    data_d  = cfg.io_cfg_data;
                    xor_d   = xor_q ^ cfg.io_cfg_data;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                en_d    = EN_ONE << idx_q;
                state_d = STROBE;
            end
            STROBE: begin
                en_d    = '0;
                state_d = HOLD;
            end
            HOLD: begin
                // The index parks on the last word instead of running past it.
                if (idx_q == LAST_IDX) begin
                    state_d = CHECK;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = LOAD;
                end
            end
            CHECK: begin
                // The checksum word never reaches the latch-bank data bus.
                if (accept) begin
                    err_d   = (cfg.io_cfg_data != xor_q);
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                en_d    = '0;
            end
        endcase
    end

    // State and datapath registers; reset drops the enables at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            xor_q   <= '0;
            data_q  <= '0;
            en_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            xor_q   <= xor_d;
            data_q  <= data_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_config_loader.sv
// tb_config_loader: directed frames checked against a timing-rule model.
// Literal expectations pin latency, enable walk and checksum behaviour.
module tb_config_loader;

    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 39;
    localparam int IDX_W     = 6;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic [WORD_W-1:0]    d_in;
    logic [NUM_WORDS-1:0] en;
    logic                 busy;
    logic                 done;
    logic                 err;

    config_loader_if #(.WORD_W(WORD_W)) cfg ();

    config_loader #(
        .WORD_W   (WORD_W),
        .NUM_WORDS(NUM_WORDS),
        .IDX_W    (IDX_W)
    ) dut (
        .clk          (clk),
        .reset        (rst_n),
        .io_start     (start),
        .cfg          (cfg),
        .io_d_in      (d_in),
        .io_configs_en(en),
        .io_busy      (busy),
        .io_done      (done),
        .io_error     (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: frame progress expressed as word count plus cycles since accept.
    bit                   m_active;
    int                   m_ph;
    int                   m_cnt;
    logic [WORD_W-1:0]    m_xor;
    logic [WORD_W-1:0]    m_d;
    logic [NUM_WORDS-1:0] m_en;
    bit                   m_busy, m_done, m_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0; m_ph = 0; m_cnt = 0;
            m_xor = '0; m_d = '0; m_en = '0;
            m_busy = 0; m_done = 0; m_err = 0;
        end else begin
            m_done = 0;
            if (!m_active) begin
                if (start) begin
                    m_active = 1; m_ph = 0; m_cnt = 0;
                    m_xor = '0; m_err = 0; m_busy = 1;
                end
            end else if (m_ph == 0) begin
                if (cfg.io_cfg_valid) begin
                    if (m_cnt < NUM_WORDS) begin
                        m_d   = cfg.io_cfg_data;
                        m_xor = m_xor ^ cfg.io_cfg_data;
                        m_ph  = 1;
                    end else begin
                        m_err    = (cfg.io_cfg_data != m_xor);
                        m_done   = 1;
                        m_busy   = 0;
                        m_active = 0;
                    end
                end
            end else if (m_ph == 1) begin
                m_en = '0;
                m_en[m_cnt] = 1'b1;
                m_ph = 2;
            end else if (m_ph == 2) begin
                m_en = '0;
                m_ph = 3;
            end else begin
                m_ph = 0;
                m_cnt++;
            end
        end
    end

    logic [WORD_W-1:0]    prev_d;
    logic [NUM_WORDS-1:0] prev_en;
    bit                   prev_ok = 0;
    int                   done_cnt = 0;
    int                   log_n = 0;
    int                   log_idx [64];
    logic [WORD_W-1:0]    log_d [64];

    // Compare process: every output against the model each cycle.
    always @(negedge clk) begin
        check("d_in", 64'(d_in), 64'(m_d));
        check("configs_en", 64'(en), 64'(m_en));
        check("cfg_ready", 64'(cfg.io_cfg_ready), 64'(m_active && m_ph == 0));
        check("busy", 64'(busy), 64'(m_busy));
        check("done", 64'(done), 64'(m_done));
        check("error", 64'(err), 64'(m_err));
        check("onehot", 64'($countones(en) <= 1), 64'(1));
        if (rst_n && prev_ok && (en != '0 || prev_en != '0))
            check("d_stable", 64'(d_in), 64'(prev_d));
        prev_d  = d_in;
        prev_en = en;
        prev_ok = rst_n;
        if (done) done_cnt++;
        if (en != '0 && log_n < 64) begin
            for (int i = 0; i < NUM_WORDS; i++)
                if (en[i]) log_idx[log_n] = i;
            log_d[log_n] = d_in;
            log_n++;
        end
    end

    int fe;

    task automatic tick();
        @(posedge clk);
        #1;
        fe++;
    endtask

    task automatic send(input logic [WORD_W-1:0] w);
        bit acc;
        int n;
        acc = 0;
        n = 0;
        cfg.io_cfg_valid = 1'b1;
        cfg.io_cfg_data  = w;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = cfg.io_cfg_ready;
            tick();
            n++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=%0d required=accept", n);
        end
    endtask

    // mode 0: back-to-back, 1: random stalls, 2: junk valid/start
    // abort_at >= 0 drops reset during the STROBE of that word.
    task automatic run_frame(input int mode, input logic [WORD_W-1:0] chk,
                             input bit chk_clear, input int abort_at);
        logic [NUM_WORDS-1:0] one;
        one = 1;
        fe = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_ready", 64'(cfg.io_cfg_ready), 64'(1));
        if (chk_clear) begin
            check("err_cleared", 64'(err), 64'(0));
            check("busy_set", 64'(busy), 64'(1));
        end
        for (int k = 0; k <= NUM_WORDS; k++) begin
            if (k > 0 && mode == 2) begin
                for (int j = 0; j < 3; j++) begin
                    cfg.io_cfg_valid = 1'b1;
                    cfg.io_cfg_data  = 32'hDEAD_BEEF;
                    start = (j == 1) && (k == 4 || k == 21);
                    tick();
                    start = 1'b0;
                end
            end else if (k > 0 && mode == 1) begin
                int g;
                g = 3 + int'($urandom_range(0, 5));
                for (int j = 0; j < g; j++) begin
                    cfg.io_cfg_valid = 1'b0;
                    tick();
                end
            end
            send(k < NUM_WORDS ? WORD_W'(k + 1) : chk);
            if (k == abort_at) begin
                tick();
                check("abort_en", 64'(en), 64'(one << k));
                rst_n = 1'b0;
                #1;
                check("rst_en", 64'(en), 64'(0));
                check("rst_d_in", 64'(d_in), 64'(0));
                check("rst_busy", 64'(busy), 64'(0));
                check("rst_ready", 64'(cfg.io_cfg_ready), 64'(0));
                cfg.io_cfg_valid = 1'b0;
                return;
            end
        end
        cfg.io_cfg_valid = 1'b0;
    endtask

    task automatic check_walk();
        check("walk_len", 64'(log_n), 64'(NUM_WORDS));
        for (int k = 0; k < NUM_WORDS && k < log_n; k++) begin
            check("walk_idx", 64'(log_idx[k]), 64'(k));
            check("walk_data", 64'(log_d[k]), 64'(k + 1));
        end
    endtask

    initial begin
        logic [WORD_W-1:0] good;
        int dc;
        cfg.io_cfg_valid = 1'b0;
        cfg.io_cfg_data  = '0;
        good = '0;
        for (int k = 1; k <= NUM_WORDS; k++) good ^= WORD_W'(k);
        check("xor_1_to_39", 64'(good), 64'(0));

        repeat (3) @(posedge clk);
        #1;
        check("rst_d_in0", 64'(d_in), 64'(0));
        check("rst_en0", 64'(en), 64'(0));
        check("rst_ready0", 64'(cfg.io_cfg_ready), 64'(0));
        check("rst_busy0", 64'(busy), 64'(0));
        check("rst_done0", 64'(done), 64'(0));
        check("rst_err0", 64'(err), 64'(0));
        rst_n = 1'b1;
        tick();

        log_n = 0;
        run_frame(0, good, 1'b1, -1);
        check("nom_latency", 64'(fe), 64'(158));
        check("nom_done", 64'(done), 64'(1));
        check("nom_err", 64'(err), 64'(0));
        check("nom_busy", 64'(busy), 64'(0));
        check("nom_d_held", 64'(d_in), 64'(39));
        check_walk();
        tick();
        check("done_one_cycle", 64'(done), 64'(0));

        run_frame(0, 32'hFFFF_FFFF, 1'b1, -1);
        check("bad_done", 64'(done), 64'(1));
        check("bad_err", 64'(err), 64'(1));
        repeat (5) tick();
        check("bad_err_sticky", 64'(err), 64'(1));

        run_frame(1, good, 1'b1, -1);
        check("bp_done", 64'(done), 64'(1));
        check("bp_err", 64'(err), 64'(0));
        repeat (2) tick();

        dc = done_cnt;
        log_n = 0;
        run_frame(2, good, 1'b1, -1);
        repeat (4) tick();
        check("ign_done_count", 64'(done_cnt - dc), 64'(1));
        check("ign_err", 64'(err), 64'(0));
        check_walk();

        run_frame(0, good, 1'b1, 10);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        log_n = 0;
        run_frame(0, good, 1'b1, -1);
        check("post_rst_latency", 64'(fe), 64'(158));
        check("post_rst_done", 64'(done), 64'(1));
        check("post_rst_err", 64'(err), 64'(0));
        check_walk();
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
